// File: rtl/ifft_128_encoder.sv
// Transmit-side modulator: 48-bit word -> 24 Hermitian data bins plus pilot ->
// 128 real Q1.15 samples, streamed out with the fft_128 input handshake.
module ifft_128_encoder (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Pushin,
  input  logic [47:0] DataIn,
  output logic        Ready,
  output logic        PushOut,
  output logic        FirstData,
  output logic [16:0] DoutR,
  output logic [16:0] DoutI
);

  typedef enum logic [1:0] {IDLE, COMPUTE, STREAM} state_t;

  state_t             state;
  logic [47:0]        hold;
  logic [47:0]        work;
  logic               full;
  logic [6:0]         n;
  logic [4:0]         term;
  logic [7:0]         rd_idx;
  logic signed [39:0] acc;
  logic signed [16:0] sbuf [128];

  logic               accept;
  logic               consume;
  logic               full_next;
  logic               wr_en;
  logic [6:0]         f;
  logic [6:0]         phase;
  logic signed [15:0] amp;
  logic signed [15:0] cos_val;
  logic signed [31:0] prod;
  logic signed [16:0] sample;

  // Quarter-wave table: round(32767*cos(2*pi*i/128)) for i = 0..32
  function automatic logic signed [15:0] qtab(input logic [5:0] idx);
    case (idx)
      6'd0:  qtab = 16'sd32767;  6'd1:  qtab = 16'sd32728;  6'd2:  qtab = 16'sd32609;
      6'd3:  qtab = 16'sd32412;  6'd4:  qtab = 16'sd32137;  6'd5:  qtab = 16'sd31785;
      6'd6:  qtab = 16'sd31356;  6'd7:  qtab = 16'sd30852;  6'd8:  qtab = 16'sd30273;
      6'd9:  qtab = 16'sd29621;  6'd10: qtab = 16'sd28898;  6'd11: qtab = 16'sd28105;
      6'd12: qtab = 16'sd27245;  6'd13: qtab = 16'sd26319;  6'd14: qtab = 16'sd25329;
      6'd15: qtab = 16'sd24279;  6'd16: qtab = 16'sd23170;  6'd17: qtab = 16'sd22005;
      6'd18: qtab = 16'sd20787;  6'd19: qtab = 16'sd19519;  6'd20: qtab = 16'sd18204;
      6'd21: qtab = 16'sd16846;  6'd22: qtab = 16'sd15446;  6'd23: qtab = 16'sd14010;
      6'd24: qtab = 16'sd12539;  6'd25: qtab = 16'sd11039;  6'd26: qtab = 16'sd9512;
      6'd27: qtab = 16'sd7962;   6'd28: qtab = 16'sd6393;   6'd29: qtab = 16'sd4808;
      6'd30: qtab = 16'sd3212;   6'd31: qtab = 16'sd1608;
      default: qtab = 16'sd0;
    endcase
  endfunction

  // Full 128-entry cosine from quadrant symmetry
  function automatic logic signed [15:0] cosq(input logic [6:0] m);
    logic [5:0]         idx;
    logic               neg;
    logic signed [15:0] mag;
    idx = {1'b0, m[4:0]};
    neg = 1'b0;
    case (m[6:5])
      2'd0: begin idx = {1'b0, m[4:0]};         neg = 1'b0; end
      2'd1: begin idx = 6'd32 - {1'b0, m[4:0]}; neg = 1'b1; end
      2'd2: begin idx = {1'b0, m[4:0]};         neg = 1'b1; end
      default: begin idx = 6'd32 - {1'b0, m[4:0]}; neg = 1'b0; end
    endcase
    mag = qtab(idx);
    cosq = neg ? -mag : mag;
  endfunction

  always_comb begin
    accept    = Pushin && Ready;
    consume   = full && ((state == IDLE) || (state == STREAM && rd_idx[7]));
    full_next = (full && !consume) || accept;
    wr_en     = (state == COMPUTE) && (term == 5'd25);

    f   = 7'd55;
    amp = 16'sd32767;
    if (term < 5'd24) begin
      f = 7'd4 + {1'b0, term, 1'b0};
      case (work[{term, 1'b0} +: 2])
        2'd0:    amp = 16'sd0;
        2'd1:    amp = 16'sd10912;
        2'd2:    amp = 16'sd21824;
        default: amp = 16'sd32767;
      endcase
    end
    phase   = f * n;
    cos_val = cosq(phase);
    prod    = amp * cos_val;
    sample  = 17'((acc + 40'sd524288) >>> 20);
  end

  always_ff @(posedge Clk) begin
    if (!Reset && wr_en) sbuf[n] <= sample;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      hold      <= '0;
      work      <= '0;
      full      <= 1'b0;
      Ready     <= 1'b1;
      PushOut   <= 1'b0;
      FirstData <= 1'b0;
      DoutR     <= '0;
      DoutI     <= '0;
      n         <= '0;
      term      <= '0;
      rd_idx    <= '0;
      acc       <= '0;
    end else begin
      if (accept) hold <= DataIn;
      full  <= full_next;
      Ready <= !full_next;
      DoutI <= '0;
      case (state)
        IDLE: begin
          PushOut   <= 1'b0;
          FirstData <= 1'b0;
          DoutR     <= '0;
          if (consume) begin
            work  <= hold;
            state <= COMPUTE;
            n     <= '0;
            term  <= '0;
            acc   <= '0;
          end
        end
        COMPUTE: begin
          if (term != 5'd25) begin
            acc  <= acc + 40'(prod);
            term <= term + 5'd1;
          end else begin
            acc  <= '0;
            term <= '0;
            n    <= n + 7'd1;
            // Sample 0 leaves on the same edge that writes sample 127
            if (n == 7'd127) begin
              state     <= STREAM;
              PushOut   <= 1'b1;
              FirstData <= 1'b1;
              DoutR     <= sbuf[0];
              rd_idx    <= 8'd1;
            end
          end
        end
        STREAM: begin
          FirstData <= 1'b0;
          if (!rd_idx[7]) begin
            PushOut <= 1'b1;
            DoutR   <= sbuf[rd_idx[6:0]];
            rd_idx  <= rd_idx + 8'd1;
          end else begin
            PushOut <= 1'b0;
            DoutR   <= '0;
            if (consume) begin
              work  <= hold;
              state <= COMPUTE;
              n     <= '0;
              term  <= '0;
              acc   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_128_encoder.sv
// Directed bench for ifft_128_encoder: latency, burst shape, sample values
// against a floating-point-derived cosine model, back-to-back and reset cases.
module tb_ifft_128_encoder;

  logic        Clk;
  logic        Reset;
  logic        Pushin;
  logic [47:0] DataIn;
  logic        Ready;
  logic        PushOut;
  logic        FirstData;
  logic [16:0] DoutR;
  logic [16:0] DoutI;

  int checks = 0;
  int errors = 0;

  localparam real PI = 3.14159265358979323846;

  ifft_128_encoder dut (
    .Clk(Clk), .Reset(Reset), .Pushin(Pushin), .DataIn(DataIn),
    .Ready(Ready), .PushOut(PushOut), .FirstData(FirstData),
    .DoutR(DoutR), .DoutI(DoutI)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cos_ref(int m);
    real r;
    r = 32767.0 * $cos(2.0 * PI * m / 128.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(-r + 0.5);
  endfunction

  function automatic int model(logic [47:0] d, int n);
    longint acc;
    logic [1:0] c;
    int a;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      c = d[2*i +: 2];
      a = (c == 2'd0) ? 0 : (c == 2'd1) ? 10912 : (c == 2'd2) ? 21824 : 32767;
      acc += longint'(a) * longint'(cos_ref(((4 + 2*i) * n) % 128));
    end
    acc += longint'(32767) * longint'(cos_ref((55 * n) % 128));
    return int'((acc + 524288) >>> 20);
  endfunction

  task automatic push_word(input logic [47:0] d);
    Pushin = 1'b1;
    DataIn = d;
    tick;
    Pushin = 1'b0;
  endtask

  task automatic wait_burst(input string tag, input int expected);
    int k;
    k = 0;
    while (PushOut !== 1'b1 && k < 6000) begin
      tick;
      k++;
    end
    check(tag, k, expected);
  endtask

  task automatic capture(input string tag, input logic [47:0] d, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      check({tag, "_pushout"}, PushOut, 1);
      check({tag, "_first"}, FirstData, (i == 0) ? 1 : 0);
      check({tag, "_douti"}, DoutI, 0);
      check($sformatf("%s_x%0d", tag, i), $signed(DoutR), model(d, i));
      tick;
    end
    if (nsamp == 128) begin
      check({tag, "_end_pushout"}, PushOut, 0);
      check({tag, "_end_doutr"}, DoutR, 0);
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      tick;
      if (PushOut !== 1'b0) seen++;
    end
    check(tag, seen, 0);
  endtask

  logic [47:0] w0, w1, w2;

  initial begin
    Reset  = 1'b1;
    Pushin = 1'b0;
    DataIn = '0;
    repeat (5) tick;
    check("rst_ready", Ready, 1);
    check("rst_pushout", PushOut, 0);
    check("rst_first", FirstData, 0);
    check("rst_doutr", DoutR, 0);
    check("rst_douti", DoutI, 0);
    Reset = 1'b0;
    tick;

    // Pilot only
    push_word(48'h0);
    check("pilot_ready_low", Ready, 0);
    wait_burst("pilot_latency", 3329);
    check("pilot_x0", $signed(DoutR), 1024);
    capture("pilot", 48'h0, 128);
    check("pilot_ready_after", Ready, 1);

    // All ones
    push_word(48'hFFFFFFFFFFFF);
    wait_burst("ones_latency", 3329);
    check("ones_x0", $signed(DoutR), 25598);
    capture("ones", 48'hFFFFFFFFFFFF, 128);

    // Patterns
    push_word(48'hA5A5A5A5A5A5);
    wait_burst("a5_latency", 3329);
    check("a5_x0", $signed(DoutR), 13300);
    capture("a5", 48'hA5A5A5A5A5A5, 128);
    push_word(48'hE23456789F1B);
    wait_burst("e2_latency", 3329);
    capture("e2", 48'hE23456789F1B, 128);

    // Back-to-back: A, B during A's compute, C dropped
    push_word(48'h123456789ABC);
    repeat (10) tick;
    check("b2b_ready_compute", Ready, 1);
    push_word(48'hFEDCBA987654);
    check("b2b_ready_full", Ready, 0);
    push_word(48'h0F0F0F0F0F0F);
    check("b2b_ready_still_full", Ready, 0);
    wait_burst("b2b_a_latency", 3317);
    capture("b2b_a", 48'h123456789ABC, 128);
    check("b2b_ready_b_consumed", Ready, 1);
    wait_burst("b2b_b_gap", 3328);
    capture("b2b_b", 48'hFEDCBA987654, 128);
    check("b2b_ready_end", Ready, 1);
    expect_quiet("b2b_c_dropped", 3600);

    // Reset mid-STREAM at sample 60
    push_word(48'h5A5A00FF3C3C);
    wait_burst("rs_latency", 3329);
    capture("rs_partial", 48'h5A5A00FF3C3C, 60);
    Reset = 1'b1;
    tick;
    check("rs_pushout", PushOut, 0);
    check("rs_ready", Ready, 1);
    check("rs_doutr", DoutR, 0);
    check("rs_first", FirstData, 0);
    check("rs_douti", DoutI, 0);
    Reset = 1'b0;
    tick;
    push_word(48'hC0FFEE123456);
    wait_burst("rs_new_latency", 3329);
    capture("rs_new", 48'hC0FFEE123456, 128);

    // Reset mid-COMPUTE with the holding register full clears both
    push_word(48'h111111111111);
    repeat (5) tick;
    push_word(48'h222222222222);
    check("rc_ready_full", Ready, 0);
    Reset = 1'b1;
    tick;
    check("rc_ready", Ready, 1);
    check("rc_pushout", PushOut, 0);
    Reset = 1'b0;
    expect_quiet("rc_quiet", 3600);

    // Random words, back-to-back
    w0 = {$urandom(), $urandom()};
    w1 = {$urandom(), $urandom()};
    w2 = {$urandom(), $urandom()};
    push_word(w0);
    repeat (3) tick;
    push_word(w1);
    wait_burst("rnd0_latency", 3325);
    capture("rnd0", w0, 128);
    push_word(w2);
    wait_burst("rnd1_gap", 3327);
    capture("rnd1", w1, 128);
    wait_burst("rnd2_gap", 3328);
    capture("rnd2", w2, 128);
    expect_quiet("rnd_quiet", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
